// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: the NOP pattern used
// for bubbles, the default reset PC and a word-alignment helper.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used for the prefetch buffer and for the PC tags of
// requests in flight. Push and pop may happen in the same cycle, even when
// the FIFO is full. Clear empties it and wins over push and pop.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointer/count/storage; a push into a full FIFO is only taken when
  // the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless while unoccupied, so no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues in-order requests under
// a credit limit, buffers responses and presents one registered
// instruction/PC pair per cycle to decode. Redirects discard wrong-path
// responses still in flight.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched_o/perf_bubble_o.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_en_i,
  input  logic [31:0] branch_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] IF_Instruction_o,
  output logic [31:0] IF_PC_o,
  output logic        IF_valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_bubble_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 2;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_q, pc_d;
  logic             valid_q, valid_d;

  logic [CNT_W-1:0] fifo_count, tag_count;
  logic [63:0]      fifo_head;
  logic [31:0]      tag_pc;
  logic [SUM_W-1:0] outstanding, credit_used;
  logic             handshake, rsp_live, fifo_empty, take, bypass;
  logic             fifo_push, fifo_pop;

  // Requests in flight are the live tags plus the responses still to be
  // discarded, so no separate outstanding counter is kept.
  always_comb begin
    outstanding = SUM_W'(tag_count) + SUM_W'(drop_cnt_q);
    credit_used = SUM_W'(fifo_count) + outstanding;
    imem_req_o  = !rst_i && !branch_en_i && (credit_used < SUM_W'(FIFO_DEPTH));
    imem_addr_o = fetch_pc_q;
    handshake   = imem_req_o && imem_gnt_i;
    rsp_live    = imem_rvalid_i && (drop_cnt_q == '0);
    fifo_empty  = (fifo_count == '0);
    take        = !branch_en_i && !flush_i && !stall_i;
    bypass      = take && fifo_empty && rsp_live;
    fifo_push   = rsp_live && !branch_en_i && !bypass;
    fifo_pop    = take && !fifo_empty;
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_prefetch (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (branch_en_i),
    .push_i  (fifo_push),
    .wdata_i ({tag_pc, imem_rdata_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count)
  );

  // PC tags of live (current-path) requests, consumed as their responses return.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_pc_tags (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (branch_en_i),
    .push_i  (handshake),
    .wdata_i (fetch_pc_q),
    .pop_i   (rsp_live),
    .rdata_o (tag_pc),
    .count_o (tag_count)
  );

  // Fetch PC advance/redirect and wrong-path drop accounting. On a redirect
  // every request in flight becomes a drop, except a response arriving in
  // that same cycle, which is discarded right away.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (branch_en_i) begin
      fetch_pc_d = word_align(branch_addr_i);
      if (imem_rvalid_i && (outstanding != '0)) begin
        drop_cnt_d = CNT_W'(outstanding - SUM_W'(1));
      end else begin
        drop_cnt_d = CNT_W'(outstanding);
      end
    end else begin
      if (handshake) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_rvalid_i && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
    end
  end

  // IF/ID register: redirect, then flush, then stall, then normal load. An
  // arriving response goes straight to the output when the buffer is empty.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (branch_en_i) begin
      instr_d = NOP_INSTRUCTION;
      pc_d    = word_align(branch_addr_i);
      valid_d = 1'b0;
    end else if (flush_i) begin
      instr_d = NOP_INSTRUCTION;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      if (!fifo_empty) begin
        pc_d    = fifo_head[63:32];
        instr_d = fifo_head[31:0];
        valid_d = 1'b1;
      end else if (rsp_live) begin
        pc_d    = tag_pc;
        instr_d = imem_rdata_i;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTRUCTION;
        valid_d = 1'b0;
      end
    end
  end

  // Stage state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
      instr_q    <= NOP_INSTRUCTION;
      pc_q       <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  assign IF_Instruction_o = instr_q;
  assign IF_PC_o          = pc_q;
  assign IF_valid_o       = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] bubble_q, bubble_d;
  logic        out_load;

  // Count output-register loads: real instructions vs bubbles.
  always_comb begin
    out_load  = branch_en_i || flush_i || !stall_i;
    fetched_d = fetched_q;
    bubble_d  = bubble_q;
    if (out_load && valid_d) begin
      fetched_d = fetched_q + 32'd1;
    end
    if (out_load && !valid_d) begin
      bubble_d = bubble_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetched_q <= '0;
      bubble_q  <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubble_q  <= bubble_d;
    end
  end

  assign perf_fetched_o = fetched_q;
  assign perf_bubble_o  = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: an in-order memory model with random
// grant and latency, a queue-based reference of the fetch rules, a
// table-driven reset-release sequence and directed corner sequences.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, flush, br, gnt, rvalid;
  logic [31:0] baddr, rdata;
  logic        imem_req_o, IF_valid_o;
  logic [31:0] imem_addr_o, IF_Instruction_o, IF_PC_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_o, perf_bubble_o;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .stall_i          (stall),
    .flush_i          (flush),
    .branch_en_i      (br),
    .branch_addr_i    (baddr),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (gnt),
    .imem_rvalid_i    (rvalid),
    .imem_rdata_i     (rdata),
    .IF_Instruction_o (IF_Instruction_o),
    .IF_PC_o          (IF_PC_o),
    .IF_valid_o       (IF_valid_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched_o   (perf_fetched_o),
    .perf_bubble_o    (perf_bubble_o)
`endif
  );

  typedef struct {logic [31:0] pc; logic wrong;} infl_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  typedef struct {logic [31:0] addr; int ready;} memrq_t;
  typedef struct {
    logic gnt; logic exp_req; logic [31:0] exp_addr; logic exp_valid; logic [31:0] exp_pc;
  } vec_t;

  infl_t  m_infl[$];
  ent_t   m_fifo[$];
  memrq_t mem_q[$];
  logic [31:0] m_fetch = RPC, m_instr = NOP_INSTRUCTION, m_pc = '0;
  logic        m_valid = 1'b0, m_pc_chk = 1'b0;
  logic [31:0] m_fetched = '0, m_bubble = '0;
  int          cyc = 0, lat = 1, n_chk = 0, n_fail = 0;
  logic        last_req;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_F0F0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive memory response, check request outputs, advance the
  // reference model, then check the registered outputs after the edge.
  task automatic tick();
    logic  m_req, m_hs, d_hs, acc_v;
    logic [31:0] hs_addr;
    ent_t  acc;
    infl_t e;
    if (!rst && mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      rvalid = 1'b1;
      rdata  = mem_word(mem_q[0].addr);
    end else begin
      rvalid = 1'b0;
      rdata  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    m_req     = !rst && !br && ((m_fifo.size() + m_infl.size()) < DEPTH);
    last_req  = imem_req_o;
    last_addr = imem_addr_o;
    chk("imem_req", 32'(imem_req_o), 32'(m_req));
    if (m_req) chk("imem_addr", imem_addr_o, m_fetch);
    d_hs    = imem_req_o && gnt;
    hs_addr = imem_addr_o;
    m_hs    = m_req && gnt;
    if (rst) begin
      m_infl.delete(); m_fifo.delete();
      m_fetch = RPC; m_instr = NOP_INSTRUCTION; m_pc = '0; m_valid = 1'b0; m_pc_chk = 1'b1;
      m_fetched = '0; m_bubble = '0;
    end else begin
      acc_v = 1'b0;
      if (rvalid && m_infl.size() > 0) begin
        e = m_infl[0];
        m_infl.delete(0);
        if (!e.wrong && !br) begin
          acc.pc = e.pc; acc.instr = rdata; acc_v = 1'b1;
        end
      end
      if (br) begin
        foreach (m_infl[i]) m_infl[i].wrong = 1'b1;
        m_fifo.delete();
        m_fetch = {baddr[31:2], 2'b00};
        m_instr = NOP_INSTRUCTION; m_valid = 1'b0; m_pc = m_fetch; m_pc_chk = 1'b1;
        m_bubble++;
      end else begin
        if (m_hs) begin
          m_infl.push_back('{pc: m_fetch, wrong: 1'b0});
          m_fetch += 32'd4;
        end
        if (acc_v) m_fifo.push_back(acc);
        if (flush) begin
          m_instr = NOP_INSTRUCTION; m_valid = 1'b0; m_bubble++;
        end else if (!stall) begin
          if (m_fifo.size() > 0) begin
            m_pc = m_fifo[0].pc; m_instr = m_fifo[0].instr; m_fifo.delete(0);
            m_valid = 1'b1; m_pc_chk = 1'b1; m_fetched++;
          end else begin
            m_instr = NOP_INSTRUCTION; m_valid = 1'b0; m_pc_chk = 1'b0; m_bubble++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) mem_q.delete();
    else begin
      if (rvalid && mem_q.size() > 0) mem_q.delete(0);
      if (d_hs) mem_q.push_back('{addr: hs_addr, ready: cyc + lat - 1});
    end
    chk("if_valid", 32'(IF_valid_o), 32'(m_valid));
    chk("if_instr", IF_Instruction_o, m_instr);
    if (m_pc_chk) chk("if_pc", IF_PC_o, m_pc);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched_o, m_fetched);
    chk("perf_bubble", perf_bubble_o, m_bubble);
`endif
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (IF_valid_o) begin
        chk(name, IF_PC_o, exp_pc);
        return;
      end
    end
    n_chk++; n_fail++;
    $display("FAIL %s: no valid output within 40 cycles, expected pc %h", name, exp_pc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    logic [31:0] prev_pc;
    int tries;
    vt[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[1] = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h00};
    vt[2] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
    vt[3] = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h00};
    vt[4] = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h00};
    vt[5] = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h00};
    vt[6] = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h00};
    vt[7] = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h00};
    vt[8] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
    vt[9] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};

    rst = 1'b1; stall = 1'b0; flush = 1'b0; br = 1'b0; baddr = '0; gnt = 1'b1;
    rvalid = 1'b0; rdata = '0; lat = 1;
    tick(); tick();
    chk("rst_req", 32'(last_req), 32'd0);
    chk("rst_valid", 32'(IF_valid_o), 32'd0);
    chk("rst_instr", IF_Instruction_o, 32'h0000_0013);
    chk("rst_pc", IF_PC_o, 32'h0);
    rst = 1'b0;

    // Reset release, back-to-back fetch, then five cycles without grant.
    for (int i = 0; i < 10; i++) begin
      gnt = vt[i].gnt;
      tick();
      chk("tbl_req", 32'(last_req), 32'(vt[i].exp_req));
      chk("tbl_addr", last_addr, vt[i].exp_addr);
      chk("tbl_valid", 32'(IF_valid_o), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) begin
        chk("tbl_pc", IF_PC_o, vt[i].exp_pc);
        chk("tbl_instr", IF_Instruction_o, mem_word(vt[i].exp_pc));
      end else begin
        chk("tbl_nop", IF_Instruction_o, 32'h0000_0013);
      end
    end

    // Stall with the buffer filling up: outputs hold, credit runs out.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_pc", IF_PC_o, 32'h0C);
      chk("stall_hold_valid", 32'(IF_valid_o), 32'd1);
    end
    chk("stall_no_req", 32'(last_req), 32'd0);
    stall = 1'b0;
    tick(); chk("drain_pc0", IF_PC_o, 32'h10);
    tick(); chk("drain_pc1", IF_PC_o, 32'h14);
    tick(); chk("drain_pc2", IF_PC_o, 32'h18);

    // Redirect with two requests in flight.
    lat = 3;
    tries = 0;
    while (m_infl.size() != 2 && tries < 20) begin tick(); tries++; end
    if (tries >= 20) begin
      n_chk++; n_fail++;
      $display("FAIL redir_setup: two requests never in flight");
    end
    br = 1'b1; baddr = 32'h0000_0104;
    tick();
    br = 1'b0;
    chk("redir_bubble", 32'(IF_valid_o), 32'd0);
    wait_valid("redir_first", 32'h104);
    wait_valid("redir_second", 32'h108);

    // Redirect coinciding with the response of the only request in flight.
    lat = 1; gnt = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0; br = 1'b1; baddr = 32'h0000_0104;
    tick();
    br = 1'b0; gnt = 1'b1;
    wait_valid("br_rv_first", 32'h104);
    wait_valid("br_rv_second", 32'h108);

    // Single-cycle flush in a steady stream.
    for (int i = 0; i < 4; i++) tick();
    prev_pc = m_pc;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(IF_valid_o), 32'd0);
    chk("flush_nop", IF_Instruction_o, 32'h0000_0013);
    tick();
    chk("post_flush_valid", 32'(IF_valid_o), 32'd1);
    chk("post_flush_pc", IF_PC_o, prev_pc + 32'd4);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 19) == 0);
      br    = ($urandom_range(0, 19) == 0);
      baddr = $urandom;
      gnt   = ($urandom_range(0, 9) < 7);
      lat   = $urandom_range(1, 3);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
